// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and sampling helper
//
// Purpose : types and helpers shared by the UART receive and transmit sides.
// Contents: uart_state_t  - frame state machine encoding
//           majority3()   - 2-of-3 vote used for mid-bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
//
// Purpose : brings an asynchronous single-bit input into the clk domain.
// Params  : RESET_VAL - value both flops take during reset (idle level of the line)
// Ports   : clk  in  - destination clock
//           nrst in  - async active-low reset
//           d    in  - asynchronous input
//           q    out - synchronised output, two clk cycles of latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote and valid/ready output
//
// Purpose : receives LSB-first frames of DATA_BITS data bits, optional parity and
//           STOP_BITS stop bits; each bit is decided by a 2-of-3 vote around mid-bit.
// Macro   : UART_RX_PARITY_EN - when defined, one parity bit follows the data and is
//           checked with sense PARITY_ODD; otherwise parity_err is tied 0.
// Params  : DATA_BITS (5..9), OVERSAMPLE (even, >= 4), STOP_BITS (1..2), PARITY_ODD (0/1)
// Ports   : clk        in  - sample clock, OVERSAMPLE x baud
//           nrst       in  - async active-low reset
//           rxd        in  - raw serial line, idle high
//           data       out - received word, stable while valid
//           valid      out - word available, held until accepted
//           ready      in  - consumer accept
//           frame_err  out - a stop bit of the word in data sampled 0
//           parity_err out - parity mismatch for the word in data
//           overrun    out - sticky: a frame was dropped because valid was not accepted
//           busy       out - receiver is inside a frame
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_S0   = TW'(MID - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(MID);
  localparam logic [TW-1:0] TICK_DEC  = TW'(MID + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t state, state_next;

  logic                 rxs;
  logic                 prev_rxs;
  logic [TW-1:0]        tick, tick_next;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp0, samp1;
  logic                 fe_pend;
  logic                 maj;
  logic                 decide;
  logic                 bit_end;
  logic                 complete;
  logic                 frame_err_new;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rxd),
    .q    (rxs)
  );

  // The third vote is the live synchronised sample, so the decision lands on tick MID+1.
  assign maj     = majority3(samp0, samp1, rxs);
  assign decide  = (state != ST_IDLE) && (tick == TICK_DEC);
  assign bit_end = (tick == TICK_LAST);
  assign busy    = (state != ST_IDLE);

  // The last stop bit's own vote is not yet in fe_pend when the frame completes.
  assign frame_err_new = fe_pend | ~maj;

  always_comb begin
    state_next   = state;
    complete     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rxs && prev_rxs) state_next = ST_START;
      end
      ST_START: begin
        if (decide && maj) state_next = ST_IDLE;
        else if (bit_end)  state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Finish at the last stop decision instead of the bit end so a
        // back-to-back start edge is never missed.
        if (decide && bit_cnt == LAST_STOP) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state == ST_IDLE || state_next == ST_IDLE || bit_end) tick_next = '0;
    else                                                       tick_next = tick + 1'b1;

    if (state_next != state)                                 bit_cnt_next = '0;
    else if (bit_end && (state == ST_DATA || state == ST_STOP)) bit_cnt_next = bit_cnt + 1'b1;
    else                                                     bit_cnt_next = bit_cnt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      prev_rxs <= 1'b1;
      tick     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      fe_pend  <= 1'b0;
    end else begin
      state    <= state_next;
      prev_rxs <= rxs;
      tick     <= tick_next;
      bit_cnt  <= bit_cnt_next;
      if (state != ST_IDLE && tick == TICK_S0) samp0 <= rxs;
      if (state != ST_IDLE && tick == TICK_S1) samp1 <= rxs;
      if (state == ST_IDLE) fe_pend <= 1'b0;
      else if (state == ST_STOP && decide && !maj) fe_pend <= 1'b1;
      // Shift in at the MSB: after DATA_BITS bits the first (LSB) bit sits at bit 0.
      if (state == ST_DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      par_bit   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (state == ST_PARITY && decide) par_bit <= maj;
      if (complete && (!valid || ready)) par_err_q <= (^shreg) ^ par_bit ^ 1'(PARITY_ODD);
    end
  end

  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete && (!valid || ready)) begin
        data      <= shreg;
        frame_err <= frame_err_new;
        valid     <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      // A completion while the held word is not being taken is dropped.
      if (valid && ready)         overrun <= 1'b0;
      else if (complete && valid) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT_A = 4 + OS * (8 + P + 1) + OS / 2;
  localparam int LAT_B = 4 + OS * (5 + P + 2) + OS / 2;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic       valid_b, fe_b, pe_b, ovr_b, busy_b;

  uart_rx_os dut (
    .clk        (clk),
    .nrst       (nrst),
    .rxd        (rxd_a),
    .data       (data_a),
    .valid      (valid_a),
    .ready      (ready_a),
    .frame_err  (fe_a),
    .parity_err (pe_a),
    .overrun    (ovr_a),
    .busy       (busy_a)
  );

  uart_rx_os #(.DATA_BITS(5), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(0)) dut5 (
    .clk        (clk),
    .nrst       (nrst),
    .rxd        (rxd_b),
    .data       (data_b),
    .valid      (valid_b),
    .ready      (ready_b),
    .frame_err  (fe_b),
    .parity_err (pe_b),
    .overrun    (ovr_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Rise monitors: count words, remember when and what appeared.
  int         rises_a = 0, rises_b = 0, hi_a = 0;
  int         rise_cyc_a = 0, rise_cyc_b = 0;
  int         st_a = 0, st_b = 0;
  logic       pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0] cap_data_a;
  logic [4:0] cap_data_b;
  logic       cap_fe_a, cap_pe_a, cap_fe_b;

  always @(negedge clk) begin
    if (valid_a) hi_a++;
    if (valid_a && !pv_a) begin
      rises_a++;
      rise_cyc_a = cyc;
      cap_data_a = data_a;
      cap_fe_a   = fe_a;
      cap_pe_a   = pe_a;
    end
    if (valid_b && !pv_b) begin
      rises_b++;
      rise_cyc_b = cyc;
      cap_data_b = data_b;
      cap_fe_b   = fe_b;
    end
    pv_a = valid_a;
    pv_b = valid_b;
  end

  task automatic drive(input int ln, input logic v);
    if (ln == 0) rxd_a = v;
    else         rxd_b = v;
    repeat (OS) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge is cycle 0 of the frame.
  task automatic send_frame(input int ln, input logic [8:0] d, input int nb,
                            input logic stop_v, input int ns, input logic par_flip);
    logic p;
    p = 1'b0;
    if (ln == 0) st_a = cyc + 1;
    else         st_b = cyc + 1;
    drive(ln, 1'b0);
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      drive(ln, d[i]);
    end
    if (P == 1) drive(ln, p ^ par_flip);
    for (int i = 0; i < ns; i++) drive(ln, stop_v);
  endtask

  int r0, h0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_flags", {fe_a, pe_a, ovr_a}, 0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single frame, ready held high
    ready_a = 1'b1;
    r0 = rises_a;
    h0 = hi_a;
    send_frame(0, 9'h055, 8, 1'b1, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t1_rises", rises_a - r0, 1);
    chk("t1_latency", rise_cyc_a - st_a, LAT_A);
    chk("t1_data", cap_data_a, 8'h55);
    chk("t1_flags", {cap_fe_a, cap_pe_a}, 0);
    chk("t1_hi_cycles", hi_a - h0, 1);

    // 2: back-to-back frames, not accepted -> overrun
    ready_a = 1'b0;
    send_frame(0, 9'h0A3, 8, 1'b1, 1, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b1, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t2_valid", valid_a, 1);
    chk("t2_data", data_a, 8'hA3);
    chk("t2_overrun", ovr_a, 1);
    chk("t2_fe", fe_a, 0);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("t2_valid_after", valid_a, 0);
    chk("t2_ovr_after", ovr_a, 0);

    // 3: short low glitch on the idle line
    ready_a = 1'b1;
    r0 = rises_a;
    rxd_a = 1'b0;
    repeat (6) @(negedge clk);
    rxd_a = 1'b1;
    chk("t3_busy_during", busy_a, 1);
    repeat (12) @(negedge clk);
    chk("t3_busy_after", busy_a, 0);
    repeat (OS * 12) @(negedge clk);
    chk("t3_no_valid", rises_a - r0, 0);

    // 4: framing error followed by a stuck-low line
    r0 = rises_a;
    send_frame(0, 9'h0FF, 8, 1'b0, 1, 1'b0);
    repeat (OS * 40) @(negedge clk);
    chk("t4_rises", rises_a - r0, 1);
    chk("t4_data", cap_data_a, 8'hFF);
    chk("t4_fe", cap_fe_a, 1);
    rxd_a = 1'b1;
    repeat (OS * 3) @(negedge clk);
    chk("t4_no_more", rises_a - r0, 1);
    chk("t4_busy", busy_a, 0);

`ifdef UART_RX_PARITY_EN
    // 5: parity checking, even sense
    send_frame(0, 9'h007, 8, 1'b1, 1, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_pe_bad", cap_pe_a, 1);
    chk("t5_data_bad", cap_data_a, 8'h07);
    send_frame(0, 9'h007, 8, 1'b1, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_pe_good", cap_pe_a, 0);
`endif

    // 6: reset in the middle of a data bit run
    r0 = rises_a;
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b1);
    nrst  = 1'b0;
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_valid", valid_a, 0);
    nrst = 1'b1;
    repeat (OS * 2) @(negedge clk);
    chk("t6_no_partial", rises_a - r0, 0);
    send_frame(0, 9'h081, 8, 1'b1, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_rises", rises_a - r0, 1);
    chk("t6_data", cap_data_a, 8'h81);
    chk("t6_flags", {cap_fe_a, cap_pe_a, ovr_a}, 0);

    // 6b: 5 data bits, 2 stop bits
    ready_b = 1'b1;
    r0 = rises_b;
    send_frame(1, 9'h015, 5, 1'b1, 2, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6b_rises", rises_b - r0, 1);
    chk("t6b_latency", rise_cyc_b - st_b, LAT_B);
    chk("t6b_data", cap_data_b, 5'h15);
    chk("t6b_fe", cap_fe_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
